// File: rtl/goose_jump_controller_if.sv
// Control and status bundle between the game controller and the goose vertical-motion engine.
interface goose_jump_controller_if #(
  parameter int unsigned HEIGHT_W = 7
) ();

  logic                jump_button;
  logic                frame_tick;
  logic                game_halt;
  logic                game_reset;
  logic                in_air;
  logic [HEIGHT_W-1:0] goose_height;
  logic                jump_start;

  modport master (
    output jump_button, frame_tick, game_halt, game_reset,
    input  in_air, goose_height, jump_start
  );

  modport slave (
    input  jump_button, frame_tick, game_halt, game_reset,
    output in_air, goose_height, jump_start
  );

endinterface

// File: rtl/goose_jump_controller.sv
// Goose vertical-motion engine: button sync/debounce, one-deep jump request,
// and a per-frame ballistic FSM producing height and airborne status.
module goose_jump_controller #(
  parameter int unsigned JUMP_V0         = 12,
  parameter int unsigned GRAVITY         = 1,
  parameter int unsigned HEIGHT_W        = 7,
  parameter int unsigned MAX_HEIGHT      = 127,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic                    clk,
  input  logic                    rst,
  goose_jump_controller_if.slave  bus
);

  localparam int unsigned VW    = HEIGHT_W + 2;
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic signed [VW-1:0] V0_S     = VW'(JUMP_V0);
  localparam logic signed [VW-1:0] G_S      = VW'(GRAVITY);
  localparam logic signed [VW-1:0] MAX_S    = VW'(MAX_HEIGHT);

  typedef enum logic [1:0] {
    GROUNDED = 2'd0,
    RISING   = 2'd1,
    FALLING  = 2'd2
  } state_t;

  localparam state_t TAKEOFF_STATE = (JUMP_V0 > GRAVITY) ? RISING : FALLING;

  logic [1:0]          sync_q;
  logic                db_q;
  logic                db_d_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                press_c;

  state_t              state_q, state_n;
  logic [HEIGHT_W-1:0] height_q, height_n;
  logic signed [VW-1:0] vel_q, vel_n;
  logic                req_q, req_n;
  logic                in_air_q;
  logic                jump_start_q, jump_start_n;
  logic signed [VW-1:0] new_h_c;
  logic signed [VW-1:0] vel_dec_c;

  // Synchroniser and debounce; game_reset deliberately leaves this path alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      db_q   <= 1'b0;
      db_d_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], bus.jump_button};
      db_d_q <= db_q;
      if (sync_q[1] != db_q) begin
        if (cnt_q == CNT_LAST) begin
          db_q  <= sync_q[1];
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign press_c = db_q & ~db_d_q;

  // Next-state, physics and request logic.
  always_comb begin
    state_n      = state_q;
    height_n     = height_q;
    vel_n        = vel_q;
    req_n        = req_q;
    jump_start_n = 1'b0;
    new_h_c      = $signed({2'b00, height_q}) + vel_q;
    vel_dec_c    = vel_q - G_S;

    if (press_c && state_q == GROUNDED && !bus.game_halt) begin
      req_n = 1'b1;
    end

    if (bus.frame_tick && !bus.game_halt) begin
      case (state_q)
        GROUNDED: begin
          // The request register is sampled, so a press on this tick waits for the next one.
          if (req_q) begin
            height_n     = HEIGHT_W'(JUMP_V0);
            vel_n        = V0_S - G_S;
            req_n        = 1'b0;
            jump_start_n = 1'b1;
            state_n      = TAKEOFF_STATE;
          end
        end
        RISING, FALLING: begin
          if (new_h_c[VW-1] || new_h_c == '0) begin
            height_n = '0;
            vel_n    = '0;
            state_n  = GROUNDED;
          end else begin
            height_n = (new_h_c > MAX_S) ? HEIGHT_W'(MAX_HEIGHT) : HEIGHT_W'(new_h_c);
            vel_n    = vel_dec_c;
            state_n  = (!vel_dec_c[VW-1] && vel_dec_c != '0) ? RISING : FALLING;
          end
        end
        default: state_n = GROUNDED;
      endcase
    end

    if (bus.game_halt) begin
      req_n = 1'b0;
    end

    if (bus.game_reset) begin
      state_n      = GROUNDED;
      height_n     = '0;
      vel_n        = '0;
      req_n        = 1'b0;
      jump_start_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= GROUNDED;
      height_q     <= '0;
      vel_q        <= '0;
      req_q        <= 1'b0;
      in_air_q     <= 1'b0;
      jump_start_q <= 1'b0;
    end else begin
      state_q      <= state_n;
      height_q     <= height_n;
      vel_q        <= vel_n;
      req_q        <= req_n;
      in_air_q     <= (state_n != GROUNDED);
      jump_start_q <= jump_start_n;
    end
  end

  assign bus.in_air       = in_air_q;
  assign bus.goose_height = height_q;
  assign bus.jump_start   = jump_start_q;

endmodule

// File: tb/tb_goose_jump_controller.sv
// Directed bench for goose_jump_controller: expected outputs are queued as each
// step is driven and compared once the DUT has registered its response.
module tb_goose_jump_controller;

  logic clk = 1'b0;
  logic rst;

  goose_jump_controller_if #(.HEIGHT_W(7)) bus ();

  goose_jump_controller #(
    .JUMP_V0         (12),
    .GRAVITY         (1),
    .HEIGHT_W        (7),
    .MAX_HEIGHT      (127),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       air;
    logic [6:0] h;
    logic       js;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // Reference heights after each frame tick of an undisturbed jump.
  int arc [25] = '{12, 23, 33, 42, 50, 57, 63, 68, 72, 75, 77, 78,
                   78, 77, 75, 72, 68, 63, 57, 50, 42, 33, 23, 12, 0};

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic air, input logic [6:0] h, input logic js, input string tag);
    exp_t e;
    e.air = air;
    e.h   = h;
    e.js  = js;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_err++;
      $error("FAIL scoreboard_underflow observed empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      n_checks++;
      assert (bus.in_air === e.air) else begin
        n_err++;
        $error("FAIL %s in_air observed %0b expected %0b", e.tag, bus.in_air, e.air);
      end
      n_checks++;
      assert (bus.goose_height === e.h) else begin
        n_err++;
        $error("FAIL %s goose_height observed %0d expected %0d", e.tag, bus.goose_height, e.h);
      end
      n_checks++;
      assert (bus.jump_start === e.js) else begin
        n_err++;
        $error("FAIL %s jump_start observed %0b expected %0b", e.tag, bus.jump_start, e.js);
      end
    end
  endtask

  // One frame tick, then compare the registered response.
  task automatic tick_chk(input logic air, input logic [6:0] h, input logic js, input string tag);
    push_exp(air, h, js, tag);
    bus.frame_tick = 1'b1;
    cycle();
    bus.frame_tick = 1'b0;
    check_pop();
  endtask

  task automatic idle_chk(input logic air, input logic [6:0] h, input logic js, input string tag);
    push_exp(air, h, js, tag);
    cycle();
    check_pop();
  endtask

  // Clean press and release, each long enough to pass the debouncer.
  task automatic press();
    bus.jump_button = 1'b1;
    repeat (10) cycle();
    bus.jump_button = 1'b0;
    repeat (10) cycle();
  endtask

  initial begin
    rst             = 1'b1;
    bus.jump_button = 1'b0;
    bus.frame_tick  = 1'b0;
    bus.game_halt   = 1'b0;
    bus.game_reset  = 1'b0;
    repeat (3) cycle();
    idle_chk(1'b0, 7'd0, 1'b0, "reset");
    rst = 1'b0;
    cycle();

    // Three-cycle glitch is shorter than the debounce window.
    bus.jump_button = 1'b1;
    repeat (3) cycle();
    bus.jump_button = 1'b0;
    repeat (10) cycle();
    tick_chk(1'b0, 7'd0, 1'b0, "glitch");

    // Full arc with an airborne press after tick 5.
    press();
    tick_chk(1'b1, 7'd12, 1'b1, "takeoff");
    idle_chk(1'b1, 7'd12, 1'b0, "js_single");
    for (int i = 1; i < 25; i++) begin
      tick_chk(arc[i] != 0, 7'(arc[i]), 1'b0, $sformatf("arc_t%0d", i + 1));
      if (i == 4) press();
    end
    tick_chk(1'b0, 7'd0, 1'b0, "post_land");

    // Halt mid-air at 57, resume, then game_reset coincident with a tick at 72.
    press();
    tick_chk(1'b1, 7'd12, 1'b1, "halt_takeoff");
    for (int i = 1; i < 6; i++) tick_chk(1'b1, 7'(arc[i]), 1'b0, $sformatf("halt_arc%0d", i + 1));
    bus.game_halt = 1'b1;
    for (int i = 0; i < 10; i++) tick_chk(1'b1, 7'd57, 1'b0, "halted");
    bus.game_halt = 1'b0;
    tick_chk(1'b1, 7'd63, 1'b0, "resume");
    tick_chk(1'b1, 7'd68, 1'b0, "resume2");
    tick_chk(1'b1, 7'd72, 1'b0, "resume3");
    bus.game_reset = 1'b1;
    tick_chk(1'b0, 7'd0, 1'b0, "greset_tick");
    bus.game_reset = 1'b0;
    tick_chk(1'b0, 7'd0, 1'b0, "after_greset");

    // A halt before the tick discards the pending request.
    press();
    bus.game_halt = 1'b1;
    idle_chk(1'b0, 7'd0, 1'b0, "halt_grounded");
    bus.game_halt = 1'b0;
    tick_chk(1'b0, 7'd0, 1'b0, "halt_cleared1");
    tick_chk(1'b0, 7'd0, 1'b0, "halt_cleared2");

    // rst mid-air at 72.
    press();
    for (int i = 0; i < 9; i++) tick_chk(1'b1, 7'(arc[i]), i == 0, $sformatf("rst_arc%0d", i + 1));
    rst = 1'b1;
    idle_chk(1'b0, 7'd0, 1'b0, "rst_midair");
    rst = 1'b0;
    tick_chk(1'b0, 7'd0, 1'b0, "after_rst");

    // Button held through game_reset gives no press until released and pressed again.
    bus.jump_button = 1'b1;
    repeat (10) cycle();
    bus.game_reset = 1'b1;
    idle_chk(1'b0, 7'd0, 1'b0, "greset_held");
    bus.game_reset = 1'b0;
    repeat (5) cycle();
    tick_chk(1'b0, 7'd0, 1'b0, "held_no_jump");
    bus.jump_button = 1'b0;
    repeat (10) cycle();
    press();
    tick_chk(1'b1, 7'd12, 1'b1, "repress");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
